// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch front end.
package if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DISCARD
    } fetch_state_e;

    localparam int WORD_BYTES = 4;
    localparam int ENTRY_W    = 64;

    // One queue slot: fetch address in the upper half, instruction below.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

endpackage

// File: rtl/if_prefetch_if.sv
// Bus bundle between the prefetch unit, instruction memory and decode.
// IF_PREFETCH_PERF_EN adds the fetch/stall performance counter outputs.
interface if_prefetch_if;
    logic        start_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;
`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;

    modport master (
        input  start_i, imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, instr_ready_i,
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, fetch_cnt_o, stall_cnt_o
    );
    modport slave (
        output start_i, imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, instr_ready_i,
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, fetch_cnt_o, stall_cnt_o
    );
`else
    modport master (
        input  start_i, imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, instr_ready_i,
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o
    );
    modport slave (
        output start_i, imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, instr_ready_i,
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o
    );
`endif
endinterface

// File: rtl/if_prefetch_fifo.sv
// Circular buffer of {pc, instr} entries with push/pop/flush and a count.
// The caller guarantees no push when full and no pop when empty.
module prefetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  entry_t        wdata,
    output entry_t        rdata,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Storage is cleared on reset so the head reads as zero; flush only rewinds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch front end: owns the PC, keeps one memory read in flight
// and queues returned words for decode. A redirect flushes and refetches.
// IF_PREFETCH_PERF_EN adds fetch and stall performance counters.
module if_prefetch
    import if_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk_i,
    input logic          rst_i,
    if_prefetch_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;
    logic          req;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [31:0]   tgt;
    logic [31:0]   nxt_pc;
    logic          flush;
    logic          push;
    logic          pop;
    logic          ack;
    logic          issue_ok;
    entry_t        wr_entry;
    entry_t        head;

    assign tgt   = bus.redirect_pc_i & ~32'h3;
    assign ack   = bus.imem_ack_i && (state != ST_IDLE);
    assign flush = bus.redirect_i;
    // Acks in DISCARD or coinciding with a redirect are dropped.
    assign push  = ack && (state == ST_REQ) && !bus.redirect_i;
    assign pop   = (cnt != '0) && bus.instr_ready_i && !bus.redirect_i;

    // Occupancy after this edge; a new request reserves one more slot.
    assign cnt_nxt  = flush ? '0 : cnt + CW'(push) - CW'(pop);
    assign issue_ok = bus.start_i && (cnt_nxt < CW'(DEPTH));
    assign nxt_pc   = bus.redirect_i ? tgt : (push ? fetch_pc + 32'(WORD_BYTES) : fetch_pc);
    assign wr_entry = {req_addr, bus.imem_data_i};

    prefetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .count (cnt)
    );

    // Fetch FSM: request issue, ack completion, and stale-ack discard.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            req      <= 1'b0;
        end else begin
            fetch_pc <= nxt_pc;
            case (state)
                ST_IDLE: begin
                    if (issue_ok) begin
                        state    <= ST_REQ;
                        req      <= 1'b1;
                        req_addr <= nxt_pc;
                    end
                end
                default: begin
                    if (ack) begin
                        if (issue_ok) begin
                            state    <= ST_REQ;
                            req      <= 1'b1;
                            req_addr <= nxt_pc;
                        end else begin
                            state <= ST_IDLE;
                            req   <= 1'b0;
                        end
                    end else if (bus.redirect_i) begin
                        // Address stays on the bus until the stale ack returns.
                        state <= ST_DISCARD;
                    end
                end
            endcase
        end
    end

    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = req_addr;
    assign bus.instr_valid_o = (cnt != '0);
    assign bus.instr_o       = head.instr;
    assign bus.pc_o          = head.pc;

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    // Count every completed memory read and every starved decode cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (ack) fetch_cnt <= fetch_cnt + 32'd1;
            if ((cnt == '0) && bus.start_i) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.fetch_cnt_o = fetch_cnt;
    assign bus.stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: expected {pc, instr} pairs go into a
// scoreboard queue; a monitor pops and compares on every accepted entry.
`timescale 1ns/1ps
module tb_if_prefetch;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat    = 1;
    logic [63:0] sb [$];

    if_prefetch_if bus();

    if_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic exp_push(input logic [31:0] pc);
        sb.push_back({pc, mem_word(pc)});
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || bus.instr_valid_o) && k < 60) begin
            cyc();
            k++;
        end
        check("drain_scoreboard", 32'(sb.size()), 32'd0);
        check("drain_valid", 32'(bus.instr_valid_o), 32'd0);
        cyc();
    endtask

    // Memory model: acks the held request after lat cycles, one-cycle pulse.
    initial begin
        int wcnt = 0;
        bus.imem_ack_i  = 1'b0;
        bus.imem_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_ack_i = 1'b0;
            if (rst || !bus.imem_req_o) begin
                wcnt = 0;
            end else begin
                wcnt++;
                if (wcnt >= lat) begin
                    bus.imem_ack_i  = 1'b1;
                    bus.imem_data_i = mem_word(bus.imem_addr_o);
                    wcnt = 0;
                end
            end
        end
    end

    // Monitor: compare each accepted head against the scoreboard.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_entry: got pc %h, expected no entry", bus.pc_o);
                end else begin
                    e = sb.pop_front();
                    check("pc_o", bus.pc_o, e[63:32]);
                    check("instr_o", bus.instr_o, e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.start_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.instr_ready_i = 1'b0;

        // Reset state
        cyc();
        cyc();
        smp();
        check("rst_req", 32'(bus.imem_req_o), 32'd0);
        check("rst_addr", bus.imem_addr_o, 32'h0);
        check("rst_valid", 32'(bus.instr_valid_o), 32'd0);
        check("rst_instr", bus.instr_o, 32'h0);
        check("rst_pc", bus.pc_o, 32'h0);
        cyc();
        rst = 1'b0;

        // Streaming: 1-cycle memory, consumer ready, request held high
        bus.instr_ready_i = 1'b1;
        bus.start_i       = 1'b1;
        for (int i = 0; i < 8; i++) exp_push(32'(i * 4));
        cyc();
        for (int i = 0; i < 7; i++) begin
            smp();
            check("stream_req", 32'(bus.imem_req_o), 32'd1);
            check("stream_addr", bus.imem_addr_o, 32'(i * 4));
            cyc();
        end
        bus.start_i = 1'b0;
        drain();

        // Consumer stall: four entries fill the queue, then one more slot
        bus.instr_ready_i = 1'b0;
        bus.start_i       = 1'b1;
        for (int i = 0; i < 5; i++) exp_push(32'(32 + i * 4));
        repeat (7) cyc();
        smp();
        check("stall_req", 32'(bus.imem_req_o), 32'd0);
        check("stall_valid", 32'(bus.instr_valid_o), 32'd1);
        check("stall_head_pc", bus.pc_o, 32'd32);
        cyc();
        bus.instr_ready_i = 1'b1;
        cyc();
        bus.instr_ready_i = 1'b0;
        smp();
        check("release_req", 32'(bus.imem_req_o), 32'd1);
        check("release_addr", bus.imem_addr_o, 32'd48);
        cyc();
        cyc();
        smp();
        check("release_one_only", 32'(bus.imem_req_o), 32'd0);
        cyc();
        smp();
        check("release_still_idle", 32'(bus.imem_req_o), 32'd0);
        cyc();
        bus.start_i       = 1'b0;
        bus.instr_ready_i = 1'b1;
        drain();

        // Redirect while a slow request to 8 is outstanding
        smp();
        lat = 4;
        cyc();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h8;
        cyc();
        bus.redirect_i    = 1'b0;
        bus.start_i       = 1'b1;
        bus.instr_ready_i = 1'b1;
        exp_push(32'h100);
        exp_push(32'h104);
        cyc();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h103;
        cyc();
        bus.redirect_i = 1'b0;
        smp();
        check("discard_req", 32'(bus.imem_req_o), 32'd1);
        check("discard_addr", bus.imem_addr_o, 32'h8);
        check("discard_valid", 32'(bus.instr_valid_o), 32'd0);
        repeat (3) cyc();
        smp();
        check("after_discard_req", 32'(bus.imem_req_o), 32'd1);
        check("after_discard_addr", bus.imem_addr_o, 32'h100);
        lat = 1;
        cyc();
        cyc();
        bus.start_i = 1'b0;
        drain();

        // Redirect coincident with ack and pop, queue fully reserved
        bus.instr_ready_i = 1'b0;
        bus.start_i       = 1'b1;
        repeat (4) cyc();
        bus.instr_ready_i = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h200;
        exp_push(32'h200);
        cyc();
        bus.redirect_i = 1'b0;
        bus.start_i    = 1'b0;
        smp();
        check("flush_valid", 32'(bus.instr_valid_o), 32'd0);
        check("flush_req", 32'(bus.imem_req_o), 32'd1);
        check("flush_addr", bus.imem_addr_o, 32'h200);
        drain();

        // PC wraps modulo 2^32
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFF8;
        bus.start_i       = 1'b1;
        exp_push(32'hFFFF_FFF8);
        exp_push(32'hFFFF_FFFC);
        exp_push(32'h0000_0000);
        cyc();
        bus.redirect_i = 1'b0;
        smp();
        check("wrap_req", 32'(bus.imem_req_o), 32'd1);
        check("wrap_addr", bus.imem_addr_o, 32'hFFFF_FFF8);
        cyc();
        cyc();
        bus.start_i = 1'b0;
        drain();

        // Reset mid-request with two queued entries
        bus.instr_ready_i = 1'b0;
        bus.start_i       = 1'b1;
        cyc();
        cyc();
        smp();
        lat = 10;
        cyc();
        rst = 1'b1;
        smp();
        check("pre_rst_valid", 32'(bus.instr_valid_o), 32'd1);
        check("pre_rst_head", bus.pc_o, 32'h4);
        check("pre_rst_req", 32'(bus.imem_req_o), 32'd1);
        cyc();
        rst               = 1'b0;
        bus.instr_ready_i = 1'b1;
        exp_push(32'h0);
        exp_push(32'h4);
        smp();
        check("mid_rst_req", 32'(bus.imem_req_o), 32'd0);
        check("mid_rst_addr", bus.imem_addr_o, 32'h0);
        check("mid_rst_valid", 32'(bus.instr_valid_o), 32'd0);
        check("mid_rst_instr", bus.instr_o, 32'h0);
        check("mid_rst_pc", bus.pc_o, 32'h0);
        lat = 1;
        cyc();
        cyc();
        bus.start_i = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
